alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 4-bit ALU.
- Adds a valid/ready handshake on input and output, and a persistent NZCV flag register with carry-in ops (ADC/SBC).
- Adds barrel shifts and an iterative shift-add multiplier that takes W cycles.
- Sits between the datapath register-read stage and write-back; one operation is in flight at a time.

Parameters:
- W, 4: operand/result width, ≥ 2.
- SW, $clog2(W): shift-amount width; the shift amount is B[SW-1:0].

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: operation request.
- in_ready, output, 1: block can accept a request.
- A, input, W: operand A.
- B, input, W: operand B / shift amount.
- ALUcntrl, input, 4: opcode.
- S, input, 1: update the flag register when this operation completes.
- out_valid, output, 1: result O is valid.
- out_ready, input, 1: consumer accepts the result.
- O, output, W: result.
- N, output, 1: flag register, negative.
- Z, output, 1: flag register, zero.
- CO, output, 1: flag register, carry.
- OVF, output, 1: flag register, overflow.

Behaviour:
- Reset (async assert, sync deassert by the integrator): state=IDLE, O=0, out_valid=0, N=Z=CO=OVF=0, multiplier registers=0. Reset mid-multiply aborts the operation; nothing is output.
- Accept occurs when in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready). A, B, ALUcntrl and S are captured on accept.
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A-B.
  - 0010 RSB: B-A.
  - 0011 BIC: A&~B.
  - 0100 AND.
  - 0101 ORR.
  - 0110 EOR.
  - 0111 XNOR.
  - 1000 ADC: A+B+CO.
  - 1001 SBC: A-B-1+CO.
  - 1010 LSL.
  - 1011 LSR.
  - 1100 ASR.
  - 1101 MUL: low W bits of A*B, unsigned.
  - 1110 CMP: A-B; O is driven, flags updated regardless of S.
  - 1111 MOV: B.
- Arithmetic is computed at W+1 bits.
  - Add: C = bit W.
  - Subtract: C = NOT borrow (1 when minuend ≥ subtrahend, unsigned).
  - V = signed overflow (operand signs agree per op, result sign differs).
  - ADC/SBC use the current registered CO value at accept time.
- Shifts: C = last bit shifted out. When the amount is 0, C is unchanged and O=A. V is unchanged.
- Logical, MOV and MUL ops update N and Z only; C and V are unchanged.
- N = O[W-1]; Z = (O==0).
- Flag write happens in the same cycle O is loaded, and only if S=1 (or the op is CMP). Flags hold otherwise.
- Latency:
  - All single-cycle ops: out_valid rises on the clock edge after accept.
  - MUL: out_valid rises exactly W cycles after accept.
- FSM:
  - IDLE: on accept of a non-MUL op, load O, set out_valid, stay in IDLE. On accept of MUL, go to MUL with acc=0, mcand=A, mplier=B, cnt=W-1.
  - MUL: each cycle, if mplier[0] then acc += mcand; then mcand<<=1, mplier>>=1. When cnt==0, load O from the final acc, set out_valid and flags, go to IDLE. Otherwise cnt--.
- Output holds while out_valid & !out_ready: O and the flags are stable and no new accept occurs.
- When out_valid & out_ready and a new accept happen in the same cycle: a single-cycle op's result replaces O and out_valid stays 1. For MUL, out_valid drops the next cycle until MUL completes.
- Inputs are ignored outside an accept; ALUcntrl changes in the MUL state have no effect.

Decomposition:
- Package alu_seq_pkg holds:
  - an opcode enum of 4-bit constants (OP_ADD … OP_MOV);
  - the FSM state enum (ST_IDLE, ST_MUL);
  - a flag-index localparam.
- Sub-module alu_seq_shifter (combinational, parameter W) computes LSL/LSR/ASR and shift carry-out. All other logic stays in the top module.

Test Plan:
1. W=4, ADD A=0111 B=0001 S=1 → next cycle O=1000, N=1, Z=0, CO=0, OVF=1.
2. SUB A=0011 B=0011 S=1 → O=0000, Z=1, CO=1, OVF=0. Then SUB A=0010 B=0101 → O=1101, N=1, CO=0.
3. Carry chain: ADD 1111+0001 S=1 (O=0000, CO=1, Z=1), then ADC 0000+0000 → O=0001, Z=0, CO=0.
4. MUL A=0011 B=0101 → in_ready=0 for 4 cycles, out_valid at accept+4, O=1111, N=1, CO/OVF unchanged. Also MUL 0110*0011 → O=0010 (truncated).
5. Backpressure: hold out_ready=0 after AND 1100&1010 → O=1000 stays stable, in_ready=0, a second request is not accepted. Release out_ready → accept occurs the same cycle.
6. Reset mid-MUL (assert rst_n=0 at cycle 2): all outputs are 0 asynchronously. After release, state is IDLE, in_ready=1, and no stale out_valid appears. Also LSL A=1001 B=0001 S=1 → O=0010, CO=1; S=0 leaves the flags unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag positions.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_RSB  = 4'b0010,
    OP_BIC  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_ORR  = 4'b0101,
    OP_EOR  = 4'b0110,
    OP_XNOR = 4'b0111,
    OP_ADC  = 4'b1000,
    OP_SBC  = 4'b1001,
    OP_LSL  = 4'b1010,
    OP_LSR  = 4'b1011,
    OP_ASR  = 4'b1100,
    OP_MUL  = 4'b1101,
    OP_CMP  = 4'b1110,
    OP_MOV  = 4'b1111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Bit positions inside the packed {N,Z,C,V} flag register.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU: input handshake with operands,
// output handshake with result and the registered NZCV flags.
interface alu_seq_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALUcntrl;
  logic         S;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] O;
  logic         N;
  logic         Z;
  logic         CO;
  logic         OVF;

  modport master (
    output in_valid, A, B, ALUcntrl, S, out_ready,
    input  in_ready, out_valid, O, N, Z, CO, OVF
  );

  modport slave (
    input  in_valid, A, B, ALUcntrl, S, out_ready,
    output in_ready, out_valid, O, N, Z, CO, OVF
  );
endinterface

// File: rtl/alu_seq_shifter.sv
// Combinational barrel shifter for LSL/LSR/ASR. The operand is widened by one
// bit so the last bit shifted out lands in a fixed position for the carry;
// amounts of W or more naturally yield the correct fill and carry.
module alu_seq_shifter
  import alu_seq_pkg::*;
#(
  parameter int W  = 4,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  a,
  input  logic [SW-1:0] amt,
  input  op_e           op,
  output logic [W-1:0]  res,
  output logic          c_out
);

  logic [W:0]        lsl_ext;
  logic [W:0]        lsr_ext;
  logic signed [W:0] asr_ext;

  // Select the shifted value and the bit that fell off the end.
  always_comb begin
    lsl_ext = {1'b0, a} << amt;
    lsr_ext = {a, 1'b0} >> amt;
    asr_ext = $signed({a, 1'b0}) >>> amt;
    res     = a;
    c_out   = 1'b0;
    case (op)
      OP_LSL: begin
        res   = lsl_ext[W-1:0];
        c_out = lsl_ext[W];
      end
      OP_LSR: begin
        res   = lsr_ext[W:1];
        c_out = lsr_ext[0];
      end
      OP_ASR: begin
        res   = asr_ext[W:1];
        c_out = asr_ext[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, persistent NZCV flags and a
// W-cycle shift-add multiplier. One operation is in flight at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; single-cycle ops complete on accept
// ST_MUL  | shift-add multiply in progress, cnt counts down to 0
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W  = 4,
  parameter int SW = $clog2(W)
) (
  input  logic clk,
  input  logic rst_n,
  alu_seq_if.slave bus
);

  // Counter must hold W-1; guard the degenerate clog2 of 1.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e              state_q, state_d;
  logic [W-1:0]        o_q;
  logic                valid_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [W-1:0]        acc_q, mcand_q, mplier_q;
  logic [CW-1:0]       cnt_q;
  logic                s_q;

  op_e                 op_in;
  logic                accept;
  logic                in_ready;
  logic                flag_wr;

  logic [W-1:0]        add_x, add_y;
  logic                add_cin;
  logic [W:0]          sum;
  logic                add_v;
  logic [W-1:0]        res;
  logic                c_new, v_new;
  logic [FLAG_W-1:0]   flags_new;

  logic [W-1:0]        sh_res;
  logic                sh_c;
  logic [W-1:0]        acc_next;
  logic                mul_done;

  assign op_in    = op_e'(bus.ALUcntrl);
  assign in_ready = (state_q == ST_IDLE) & (~valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign flag_wr  = bus.S | (op_in == OP_CMP);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.O         = o_q;
  assign bus.N         = flags_q[FLAG_N];
  assign bus.Z         = flags_q[FLAG_Z];
  assign bus.CO        = flags_q[FLAG_C];
  assign bus.OVF       = flags_q[FLAG_V];

  alu_seq_shifter #(.W(W), .SW(SW)) u_shifter (
    .a     (bus.A),
    .amt   (bus.B[SW-1:0]),
    .op    (op_in),
    .res   (sh_res),
    .c_out (sh_c)
  );

  // Shared adder: every arithmetic op is x + y + cin with y possibly inverted,
  // so carry is bit W (not-borrow for subtracts) and V follows one sign rule.
  always_comb begin
    add_x   = bus.A;
    add_y   = bus.B;
    add_cin = 1'b0;
    case (op_in)
      OP_SUB, OP_CMP: begin
        add_y   = ~bus.B;
        add_cin = 1'b1;
      end
      OP_RSB: begin
        add_x   = bus.B;
        add_y   = ~bus.A;
        add_cin = 1'b1;
      end
      OP_ADC: add_cin = flags_q[FLAG_C];
      OP_SBC: begin
        add_y   = ~bus.B;
        add_cin = flags_q[FLAG_C];
      end
      default: ;
    endcase
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    add_v = (add_x[W-1] == add_y[W-1]) & (sum[W-1] != add_x[W-1]);
  end

  // Single-cycle result and the C/V values it would write; ops that leave
  // C or V alone simply pass the current register value through.
  always_comb begin
    res   = '0;
    c_new = flags_q[FLAG_C];
    v_new = flags_q[FLAG_V];
    case (op_in)
      OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC, OP_CMP: begin
        res   = sum[W-1:0];
        c_new = sum[W];
        v_new = add_v;
      end
      OP_BIC:  res = bus.A & ~bus.B;
      OP_AND:  res = bus.A & bus.B;
      OP_ORR:  res = bus.A | bus.B;
      OP_EOR:  res = bus.A ^ bus.B;
      OP_XNOR: res = ~(bus.A ^ bus.B);
      OP_LSL, OP_LSR, OP_ASR: begin
        res = sh_res;
        if (bus.B[SW-1:0] != '0) c_new = sh_c;
      end
      OP_MOV:  res = bus.B;
      default: ;
    endcase
    flags_new            = flags_q;
    flags_new[FLAG_N]    = res[W-1];
    flags_new[FLAG_Z]    = (res == '0);
    flags_new[FLAG_C]    = c_new;
    flags_new[FLAG_V]    = v_new;
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done = (state_q == ST_MUL) && (cnt_q == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: only a MUL accept leaves IDLE; the final multiply step returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && op_in == OP_MUL) state_d = ST_MUL;
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result, flag and multiplier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q      <= '0;
      valid_q  <= 1'b0;
      flags_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      s_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op_in == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= bus.A;
              mplier_q <= bus.B;
              cnt_q    <= CW'(W - 1);
              s_q      <= bus.S;
              valid_q  <= 1'b0;
            end else begin
              o_q     <= res;
              valid_q <= 1'b1;
              if (flag_wr) flags_q <= flags_new;
            end
          end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) begin
            o_q     <= acc_next;
            valid_q <= 1'b1;
            if (s_q) begin
              flags_q[FLAG_N] <= acc_next[W-1];
              flags_q[FLAG_Z] <= (acc_next == '0);
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=4): a transaction-level reference model
// compared every cycle, plus literal expectations from hand calculation.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit m_valid, m_busy, m_mul_s, m_acc;
  int m_left, m_o, m_mul_o;
  bit m_n, m_z, m_c, m_v;

  function automatic bit m_ready();
    return !m_busy && (!m_valid || bus.out_ready);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Plain-arithmetic evaluation of one single-cycle op into the model.
  task automatic model_single(input int op, input int a, input int b, input bit s);
    int r, sr, n, sa, sb;
    bit c, v, cu, vu;
    sa = sgn(a); sb = sgn(b);
    r = 0; sr = 0; c = m_c; v = m_v; cu = 0; vu = 0;
    n = b & 3;
    case (op)
      0:  begin r = a + b; c = (r >= 16); sr = sa + sb; cu = 1; vu = 1; end
      1, 14: begin r = a - b; c = (a >= b); sr = sa - sb; cu = 1; vu = 1; end
      2:  begin r = b - a; c = (b >= a); sr = sb - sa; cu = 1; vu = 1; end
      3:  r = a & ~b;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = ~(a ^ b);
      8:  begin r = a + b + int'(m_c); c = (r >= 16); sr = sa + sb + int'(m_c); cu = 1; vu = 1; end
      9:  begin r = a - b - 1 + int'(m_c); c = (r >= 0); sr = sa - sb - 1 + int'(m_c); cu = 1; vu = 1; end
      10, 11, 12: begin
        if (n == 0) r = a;
        else begin
          cu = 1;
          if (op == 10) begin r = a << n; c = ((a >> (4 - n)) & 1) != 0; end
          else begin
            c = ((a >> (n - 1)) & 1) != 0;
            r = (op == 11) ? (a >> n) : (sa >>> n);
          end
        end
      end
      default: r = b;
    endcase
    if (vu) v = (sr < -8) || (sr > 7);
    r = r & 15;
    m_o = r;
    if (s || op == 14) begin
      m_n = r[3];
      m_z = (r == 0);
      if (cu) m_c = c;
      if (vu) m_v = v;
    end
  endtask

  // Model advance on each clock edge; async reset mirrors the DUT contract.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_busy = 0; m_left = 0; m_o = 0; m_mul_o = 0; m_mul_s = 0;
      m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    end else begin
      m_acc = bus.in_valid && m_ready();
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_valid = 1; m_o = m_mul_o;
          if (m_mul_s) begin m_n = m_mul_o[3]; m_z = (m_mul_o == 0); end
        end
      end else if (m_acc) begin
        if (bus.ALUcntrl == 4'd13) begin
          m_busy = 1; m_left = W; m_valid = 0;
          m_mul_o = (int'(bus.A) * int'(bus.B)) % 16;
          m_mul_s = bus.S;
        end else begin
          model_single(int'(bus.ALUcntrl), int'(bus.A), int'(bus.B), bus.S);
          m_valid = 1;
        end
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
      if (m_valid) chk("O", 32'(bus.O), 32'(m_o));
      chk("flags", 32'({bus.N, bus.Z, bus.CO, bus.OVF}), 32'({m_n, m_z, m_c, m_v}));
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic s);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.ALUcntrl = op; bus.S = s;
    while (!m_ready() && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: op %0h not accepted within 50 cycles", op);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] flg();
    return 32'({bus.N, bus.Z, bus.CO, bus.OVF});
  endfunction

  logic [3:0] x_op [14] = '{4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hC,
                            4'hC, 4'hE, 4'hF, 4'h0, 4'h1, 4'hD};
  logic [3:0] x_a  [14] = '{4'h3, 4'hF, 4'h9, 4'hA, 4'h5, 4'h5, 4'hB, 4'h8,
                            4'h6, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
  logic [3:0] x_b  [14] = '{4'h1, 4'h5, 4'h2, 4'h6, 4'h3, 4'h3, 4'h2, 4'h3,
                            4'h0, 4'h5, 4'h9, 4'h8, 4'h1, 4'h7};
  logic       x_s  [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.ALUcntrl = 0; bus.S = 0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_O", 32'(bus.O), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_flags", flg(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // ADD overflow into the sign bit.
    do_op(4'h0, 4'h7, 4'h1, 1);
    @(negedge clk);
    chk("add_O", 32'(bus.O), 32'h8);
    chk("add_flags", flg(), 32'b1001);

    // SUB equal operands, then a borrowing SUB.
    do_op(4'h1, 4'h3, 4'h3, 1);
    @(negedge clk);
    chk("sub0_O", 32'(bus.O), 0);
    chk("sub0_flags", flg(), 32'b0110);
    do_op(4'h1, 4'h2, 4'h5, 1);
    @(negedge clk);
    chk("sub1_O", 32'(bus.O), 32'hD);
    chk("sub1_flags", flg(), 32'b1000);

    // Carry chain into ADC.
    do_op(4'h0, 4'hF, 4'h1, 1);
    @(negedge clk);
    chk("addc_O", 32'(bus.O), 0);
    chk("addc_flags", flg(), 32'b0110);
    do_op(4'h8, 4'h0, 4'h0, 1);
    @(negedge clk);
    chk("adc_O", 32'(bus.O), 1);
    chk("adc_flags", flg(), 32'b0000);

    // Multiplier latency and result.
    do_op(4'hD, 4'h3, 4'h5, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mul_busy_ready", 32'(bus.in_ready), 0);
      chk("mul_busy_valid", 32'(bus.out_valid), 0);
    end
    @(negedge clk);
    chk("mul_valid", 32'(bus.out_valid), 1);
    chk("mul_O", 32'(bus.O), 32'hF);
    chk("mul_flags", flg(), 32'b1000);
    do_op(4'hD, 4'h6, 4'h3, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mul_trunc_O", 32'(bus.O), 32'h2);

    // Backpressure holds the result and blocks new requests.
    @(posedge clk); #1;
    bus.out_ready = 0;
    do_op(4'h4, 4'hC, 4'hA, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_O", 32'(bus.O), 32'h8);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1; bus.A = 4'hC; bus.B = 4'hA; bus.ALUcntrl = 4'h6; bus.S = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_O", 32'(bus.O), 32'h8);
      chk("bp_hold_valid", 32'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
    chk("bp_new_O", 32'(bus.O), 32'h6);
    chk("bp_new_valid", 32'(bus.out_valid), 1);

    // Remaining opcodes, boundaries and flag-hold cases, checked by the model.
    for (int i = 0; i < 14; i++) begin
      do_op(x_op[i], x_a[i], x_b[i], x_s[i]);
      if (x_op[i] == 4'hD) repeat (W) @(posedge clk);
    end
    repeat (2) @(negedge clk);

    // Reset in the middle of a multiply.
    do_op(4'hD, 4'h3, 4'h5, 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_O", 32'(bus.O), 0);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_flags", flg(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(bus.in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("postrst_no_valid", 32'(bus.out_valid), 0);
    end

    // Shift carry, then a flag-preserving shift with S=0.
    do_op(4'hA, 4'h9, 4'h1, 1);
    @(negedge clk);
    chk("lsl_O", 32'(bus.O), 32'h2);
    chk("lsl_flags", flg(), 32'b0010);
    do_op(4'hA, 4'h8, 4'h1, 0);
    @(negedge clk);
    chk("lsl_s0_O", 32'(bus.O), 0);
    chk("lsl_s0_flags", flg(), 32'b0010);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
